// File: rtl/store_pkg.sv
// Shared definitions for the store read-modify-write path: store opcodes,
// controller states and the store-opcode decode helper.
package store_pkg;

  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    MERGE = 3'd3,
    WRITE = 3'd4
  } state_e;

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: replaces the byte/halfword selected by the
// little-endian offset inside the old word. SW passes the new word through.
// Kept standalone so byte-enable memories can reuse it.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] new_i,
  input  logic [5:0]  op_i,
  input  logic [1:0]  off_i,
  output logic [31:0] word_o
);

  // Start from the old word and overwrite only the addressed lane.
  always_comb begin
    word_o = old_i;
    case (op_i)
      OP_SB: word_o[8*off_i +: 8] = new_i[7:0];
      OP_SH: begin
        // Offset bit 0 is not part of the halfword lane select.
        if (off_i[1]) word_o[31:16] = new_i[15:0];
        else          word_o[15:0]  = new_i[15:0];
      end
      OP_SW:   word_o = new_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store unit for a word-wide data memory without byte enables.
// SW writes directly; SB/SH read the word, merge the new lane and write back.
// Optional macro STORE_MISALIGN_TRAP_EN: misaligned SH/SW are accepted,
// dropped and flagged with a one-cycle misalign pulse.
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        opcode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              stall,
  output logic              done,
  output logic              misalign
);

  localparam logic [1:0] LAT_M1 = 2'(MEM_RD_LAT - 1);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       merged;
  logic              accept, trap;

  assign accept = req_valid && req_ready && is_store(opcode);

`ifdef STORE_MISALIGN_TRAP_EN
  assign trap     = accept && (((opcode == OP_SH) && addr[0]) ||
                               ((opcode == OP_SW) && (addr[1:0] != 2'b00)));
  assign misalign = trap;
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  store_lane_merge u_merge (
    .old_i  (mem_rdata),
    .new_i  (data_q),
    .op_i   (op_q),
    .off_i  (addr_q[1:0]),
    .word_o (merged)
  );

  // State and request registers; reset abandons any store in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      op_q    <= 6'd0;
      addr_q  <= '0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic; data_q holds the store data, then the merged word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = opcode;
          addr_d = addr;
          data_d = wdata;
          if (!trap) state_d = (opcode == OP_SW) ? WRITE : READ;
        end
      end
      READ: begin
        cnt_d   = LAT_M1;
        state_d = (LAT_M1 != 2'd0) ? WAIT : MERGE;
      end
      WAIT: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_d == 2'd0) state_d = MERGE;
      end
      MERGE: begin
        data_d  = merged;
        state_d = WRITE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory strobes and pipeline handshake decoded from the current state.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_re    = (state_q == READ);
    mem_we    = (state_q == WRITE);
    done      = (state_q == WRITE);
    mem_wdata = (state_q == WRITE) ? data_q : 32'd0;
    stall     = (state_q != IDLE) || accept;
    mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
- Write-direction counterpart of the load-extraction path in the memory stage.
- Accepts store requests (SB/SH/SW) from the EX/MEM register and drives the word-wide data memory, which has no byte enables.
- Full-word stores go straight to memory. Sub-word stores use a read-modify-write sequence that merges the new byte/halfword into the existing word.
- Raises a stall to the pipeline while busy.

Parameters:
- ADDR_W, 32, byte address width.
- MEM_RD_LAT, 1, data-memory read latency in cycles; legal values are 1 and 2.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  store request present.
- req_ready  output  1  unit idle and able to accept a request.
- opcode  input  6  store opcode: SB=6'h28, SH=6'h29, SW=6'h2B. Any other value is ignored.
- addr  input  ADDR_W  byte address (ALU result).
- wdata  input  32  store data (read data 2); the low bits are used for SB/SH.
- mem_addr  output  ADDR_W  word-aligned memory address.
- mem_re  output  1  memory read strobe.
- mem_rdata  input  32  memory read data, valid MEM_RD_LAT cycles after mem_re.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  32  merged write word.
- stall  output  1  freeze the upstream pipeline.
- done  output  1  one-cycle pulse when the store is committed.
- misalign  output  1  one-cycle pulse on an illegal alignment (only when the optional feature is enabled).

Behaviour:
- Handshake
  - A request is accepted when req_valid && req_ready && opcode is SB/SH/SW.
  - The unit latches opcode, addr and wdata on accept.
  - req_ready = (state==IDLE).
  - Invalid opcodes with req_valid high are ignored; they produce no stall and no memory activity.
- Address and lane rules
  - mem_addr = {addr_q[ADDR_W-1:2], 2'b00} in every state.
  - Little-endian lanes: byte lane k = bits [8k+7:8k], where k = addr_q[1:0].
  - Halfword lane = addr_q[1] (0 gives [15:0], 1 gives [31:16]).
- States
  - IDLE: no strobes driven.
  - SW accept -> WRITE.
  - SB/SH accept -> READ.
  - READ: mem_re=1 for exactly one cycle. A wait counter loads MEM_RD_LAT-1; the FSM moves to WAIT if the count is nonzero, otherwise to MERGE.
  - WAIT: the counter decrements; at 0 the FSM moves to MERGE.
  - MERGE: captures mem_rdata and replaces the selected lane with wdata_q[7:0] (SB) or wdata_q[15:0] (SH), then moves to WRITE.
  - WRITE: mem_we=1 and mem_wdata = merged word (SW: wdata_q unchanged) for exactly one cycle; done=1 in the same cycle; next state is IDLE.
- Stall
  - stall=1 from the accept cycle (combinational on the accepted request) through the WRITE cycle inclusive.
  - stall is deasserted in the cycle after WRITE.
- Latency
  - SW: write occurs 1 cycle after accept.
  - SB/SH: write occurs 3+(MEM_RD_LAT-1) cycles after accept.
- Back-to-back requests: the next request can be accepted in the first IDLE cycle after WRITE. There is no accept during WRITE.
- Reset
  - The state register returns to IDLE and the counter clears.
  - All outputs are 0 except req_ready=1.
  - Reset asserted mid-sequence abandons the store: no mem_we is issued and no done pulse is produced.
- mem_wdata = 0 outside WRITE.

Optional Feature:
- Macro: STORE_MISALIGN_TRAP_EN.
- Defined
  - SH with addr[0]=1, or SW with addr[1:0]!=0, is accepted and then dropped.
  - The unit pulses misalign for one cycle, goes IDLE to IDLE, and raises no mem_re/mem_we and no done.
  - stall is asserted for that single accept cycle only.
- Undefined
  - The misalign output is tied to 0.
  - SH ignores addr[0], and SW ignores addr[1:0].

Decomposition:
- Package store_pkg holds:
  - opcode constants OP_SB/OP_SH/OP_SW;
  - the state enum (IDLE, READ, WAIT, MERGE, WRITE);
  - a function that checks whether an opcode is a store.
- One sub-module, store_lane_merge: a purely combinational merge of old word, new data, opcode and addr[1:0] into the new word. It is shared with future byte-enable memories.

Test Plan:
- SW wdata=32'hDEADBEEF, addr=32'h100 -> next cycle mem_we=1, mem_addr=32'h100, mem_wdata=32'hDEADBEEF, done=1; stall high for 2 cycles.
- Memory holds 32'h11223344 at 0x200; SB wdata=32'h000000AA, addr=32'h202 -> mem_re one cycle, then mem_wdata=32'h11AA3344; done on the 3rd cycle after accept.
- SH wdata=32'h0000BEEF, addr=32'h206 onto 32'hCAFEF00D -> mem_wdata=32'hBEEFF00D; repeat with MEM_RD_LAT=2 -> write 1 cycle later.
- rst_n driven low in the MERGE cycle of an SB -> no mem_we, no done; req_ready=1, stall=0 after the reset edge.
- With STORE_MISALIGN_TRAP_EN: SW addr=32'h101 -> misalign pulse, no strobes. Without it: the write goes to 32'h100.
- Back-to-back SB then SW with req_valid held -> the second is accepted in the first IDLE cycle; opcode 6'h23 with req_valid -> no activity, stall=0.
